// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings and clock-mode constants,
// common to the SPI controller and the SPI peripheral.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic MODE_CPOL_LOW      = 1'b0;
    localparam logic MODE_CPOL_HIGH     = 1'b1;
    localparam logic MODE_CPHA_LEADING  = 1'b0;
    localparam logic MODE_CPHA_TRAILING = 1'b1;

endpackage

// File: rtl/spi_input_synchronizer.sv
// Two-flop synchronizer for one asynchronous input, with a selectable reset
// value so the synchronized level matches the line's idle level after reset.
module spi_input_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage metastability filter
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI responder: oversamples sclk/mosi/cs on the system clock, shifts words
// MSB-first, with a single-entry TX holding register and a pulsed RX port.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic CPOL       = MODE_CPOL_LOW,
    parameter logic CPHA       = MODE_CPHA_LEADING
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_sync_s;
    logic mosi_sync_s;
    logic cs_sync_s;

    spi_input_synchronizer #(.RESET_VALUE(CPOL)) u_sync_sclk (
        .clock(clock), .reset(reset), .async_in(sclk), .sync_out(sclk_sync_s)
    );
    spi_input_synchronizer #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .async_in(mosi), .sync_out(mosi_sync_s)
    );
    spi_input_synchronizer #(.RESET_VALUE(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .async_in(cs), .sync_out(cs_sync_s)
    );

    spi_state_e            state_r, state_n;
    logic                  sclk_prev_r, cs_prev_r;
    logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_n;
    logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_n;
    logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_n;
    logic [DATA_WIDTH-1:0] hold_r, hold_n;
    logic                  full_r, full_n;
    logic                  load_pending_r, load_pending_n;
    logic                  first_shift_r, first_shift_n;
    logic [DATA_WIDTH-1:0] rx_data_r, rx_data_n;
    logic                  rx_valid_r, rx_valid_n;
    logic                  underrun_r, underrun_n;
    logic                  miso_oe_r, miso_oe_n;
    logic                  miso_r, miso_n;
    logic                  busy_r, busy_n;
    logic                  tx_ready_r, tx_ready_n;
    logic                  load_s;

    logic leading_s, trailing_s, sample_edge_s, shift_edge_s, cs_fall_s, capture_s;
    logic [DATA_WIDTH-1:0] rx_word_s;

    assign leading_s     = (sclk_prev_r == CPOL) && (sclk_sync_s != CPOL);
    assign trailing_s    = (sclk_prev_r != CPOL) && (sclk_sync_s == CPOL);
    assign sample_edge_s = (CPHA == MODE_CPHA_TRAILING) ? trailing_s : leading_s;
    assign shift_edge_s  = (CPHA == MODE_CPHA_TRAILING) ? leading_s : trailing_s;
    assign cs_fall_s     = cs_prev_r && !cs_sync_s;
    assign capture_s     = tx_valid && !full_r;
    assign rx_word_s     = {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_s};

    // Next-state, datapath and output decode
    always_comb begin
        state_n        = state_r;
        bit_cnt_n      = bit_cnt_r;
        rx_shift_n     = rx_shift_r;
        tx_shift_n     = tx_shift_r;
        hold_n         = hold_r;
        full_n         = full_r;
        load_pending_n = load_pending_r;
        first_shift_n  = first_shift_r;
        rx_data_n      = rx_data_r;
        rx_valid_n     = 1'b0;
        underrun_n     = 1'b0;
        miso_oe_n      = miso_oe_r;
        load_s         = 1'b0;

        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_n        = ACTIVE;
                    bit_cnt_n      = {CNT_W{1'b0}};
                    rx_shift_n     = {DATA_WIDTH{1'b0}};
                    load_s         = 1'b1;
                    load_pending_n = 1'b0;
                    first_shift_n  = 1'b1;
                    miso_oe_n      = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_sync_s) begin
                    // Deselect discards any partial word
                    state_n        = IDLE;
                    bit_cnt_n      = {CNT_W{1'b0}};
                    load_pending_n = 1'b0;
                    miso_oe_n      = 1'b0;
                end else if (sample_edge_s) begin
                    rx_shift_n = rx_word_s;
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_n  = {CNT_W{1'b0}};
                        rx_data_n  = rx_word_s;
                        rx_valid_n = 1'b1;
                        if (CPHA == MODE_CPHA_TRAILING) begin
                            load_s        = 1'b1;
                            first_shift_n = 1'b1;
                        end else begin
                            load_pending_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (shift_edge_s) begin
                    if (CPHA == MODE_CPHA_TRAILING) begin
                        // The freshly loaded MSB is already on miso; skip one advance
                        if (first_shift_r) begin
                            first_shift_n = 1'b0;
                        end else begin
                            tx_shift_n = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (load_pending_r) begin
                            load_s         = 1'b1;
                            load_pending_n = 1'b0;
                        end else begin
                            tx_shift_n = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    state_n = ACTIVE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (load_s) begin
            tx_shift_n = full_r ? hold_r : {DATA_WIDTH{1'b0}};
            underrun_n = !full_r;
        end else begin
            underrun_n = 1'b0;
        end

        // A same-cycle capture wins: the load above already took the old word
        if (capture_s) begin
            hold_n = tx_data;
            full_n = 1'b1;
        end else if (load_s) begin
            full_n = 1'b0;
        end else begin
            full_n = full_r;
        end

        miso_n     = miso_oe_n && tx_shift_n[DATA_WIDTH-1];
        busy_n     = (state_n == ACTIVE);
        tx_ready_n = !full_n;
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            sclk_prev_r    <= CPOL;
            cs_prev_r      <= 1'b1;
            bit_cnt_r      <= {CNT_W{1'b0}};
            rx_shift_r     <= {DATA_WIDTH{1'b0}};
            tx_shift_r     <= {DATA_WIDTH{1'b0}};
            hold_r         <= {DATA_WIDTH{1'b0}};
            full_r         <= 1'b0;
            load_pending_r <= 1'b0;
            first_shift_r  <= 1'b0;
            rx_data_r      <= {DATA_WIDTH{1'b0}};
            rx_valid_r     <= 1'b0;
            underrun_r     <= 1'b0;
            miso_oe_r      <= 1'b0;
            miso_r         <= 1'b0;
            busy_r         <= 1'b0;
            tx_ready_r     <= 1'b1;
        end else begin
            state_r        <= state_n;
            sclk_prev_r    <= sclk_sync_s;
            cs_prev_r      <= cs_sync_s;
            bit_cnt_r      <= bit_cnt_n;
            rx_shift_r     <= rx_shift_n;
            tx_shift_r     <= tx_shift_n;
            hold_r         <= hold_n;
            full_r         <= full_n;
            load_pending_r <= load_pending_n;
            first_shift_r  <= first_shift_n;
            rx_data_r      <= rx_data_n;
            rx_valid_r     <= rx_valid_n;
            underrun_r     <= underrun_n;
            miso_oe_r      <= miso_oe_n;
            miso_r         <= miso_n;
            busy_r         <= busy_n;
            tx_ready_r     <= tx_ready_n;
        end
    end

    assign miso     = miso_r;
    assign miso_oe  = miso_oe_r;
    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign underrun = underrun_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench: a mode-0 and a mode-3 responder driven by a bit-banged
// controller running at clock/8, with hand-computed expected words.
module tb_spi_peripheral;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_m0 = 1'b1;
    logic       cs_m3 = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid_m0 = 1'b0;
    logic       tx_valid_m3 = 1'b0;

    logic       miso_m0, miso_oe_m0, tx_ready_m0, rx_valid_m0, underrun_m0, busy_m0;
    logic [7:0] rx_data_m0;
    logic       miso_m3, miso_oe_m3, tx_ready_m3, rx_valid_m3, underrun_m3, busy_m3;
    logic [7:0] rx_data_m3;

    int vectors = 0;
    int miscompares = 0;
    int rx_cnt_m0 = 0, rx_cnt_m3 = 0, und_cnt_m0 = 0, und_cnt_m3 = 0;
    logic [7:0] rx_prev_m3 = 8'h00, rx_last_m3 = 8'h00;
    logic miso_seen_m0 = 1'b0;

    always #5 clock = ~clock;

    spi_peripheral #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs_m0),
        .miso(miso_m0), .miso_oe(miso_oe_m0), .tx_data(tx_data), .tx_valid(tx_valid_m0),
        .tx_ready(tx_ready_m0), .rx_data(rx_data_m0), .rx_valid(rx_valid_m0),
        .underrun(underrun_m0), .busy(busy_m0)
    );

    spi_peripheral #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs_m3),
        .miso(miso_m3), .miso_oe(miso_oe_m3), .tx_data(tx_data), .tx_valid(tx_valid_m3),
        .tx_ready(tx_ready_m3), .rx_data(rx_data_m3), .rx_valid(rx_valid_m3),
        .underrun(underrun_m3), .busy(busy_m3)
    );

    // Event monitors sampled on the inactive clock edge
    always @(negedge clock) begin
        if (rx_valid_m0) rx_cnt_m0 = rx_cnt_m0 + 1;
        if (underrun_m0) und_cnt_m0 = und_cnt_m0 + 1;
        if (underrun_m3) und_cnt_m3 = und_cnt_m3 + 1;
        if (miso_m0) miso_seen_m0 = 1'b1;
        if (rx_valid_m3) begin
            rx_cnt_m3  = rx_cnt_m3 + 1;
            rx_prev_m3 = rx_last_m3;
            rx_last_m3 = rx_data_m3;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One sclk half-period; optionally offers a TX word in its first cycle
    task automatic half_phase(input int mode, input bit push, input logic [7:0] w);
        if (push) begin
            tx_data = w;
            if (mode == 0) tx_valid_m0 = 1'b1;
            else           tx_valid_m3 = 1'b1;
            cycles(1);
            tx_valid_m0 = 1'b0;
            tx_valid_m3 = 1'b0;
            cycles(3);
        end else begin
            cycles(4);
        end
    endtask

    task automatic xfer(input int mode, input logic [7:0] out_b, input int nbits,
                        input bit push, input logic [7:0] push_w, output logic [7:0] in_b);
        logic pol;
        pol  = (mode == 3);
        in_b = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (mode == 0) begin
                mosi = out_b[i];
                half_phase(mode, push && (i == 3), push_w);
                sclk = ~pol;
                in_b[i] = miso_m0;
                half_phase(mode, 1'b0, 8'h00);
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = out_b[i];
                half_phase(mode, push && (i == 3), push_w);
                sclk = pol;
                in_b[i] = miso_m3;
                half_phase(mode, 1'b0, 8'h00);
            end
        end
    endtask

    task automatic check_reset_m0(input string tag);
        check({tag, "_miso"},     miso_m0,     1'b0);
        check({tag, "_miso_oe"},  miso_oe_m0,  1'b0);
        check({tag, "_tx_ready"}, tx_ready_m0, 1'b1);
        check({tag, "_rx_data"},  rx_data_m0,  8'h00);
        check({tag, "_rx_valid"}, rx_valid_m0, 1'b0);
        check({tag, "_underrun"}, underrun_m0, 1'b0);
        check({tag, "_busy"},     busy_m0,     1'b0);
    endtask

    initial begin
        logic [7:0] r1, r2;
        int base_rx, base_und;

        // Reset
        cycles(3);
        check_reset_m0("rst");
        check("rst_m3_tx_ready", tx_ready_m3, 1'b1);
        check("rst_m3_busy", busy_m3, 1'b0);
        reset = 1'b0;
        cycles(4);

        // Mode 0: preload A5, controller sends 3C
        tx_data = 8'hA5; tx_valid_m0 = 1'b1;
        cycles(1);
        tx_valid_m0 = 1'b0;
        check("m0_tx_ready_full", tx_ready_m0, 1'b0);
        cs_m0 = 1'b0;
        cycles(8);
        check("m0_busy", busy_m0, 1'b1);
        check("m0_miso_oe", miso_oe_m0, 1'b1);
        check("m0_no_underrun", und_cnt_m0, 0);
        xfer(0, 8'h3C, 8, 1'b0, 8'h00, r1);
        cycles(8);
        cs_m0 = 1'b1;
        cycles(8);
        check("m0_ctrl_rx", r1, 8'hA5);
        check("m0_rx_data", rx_data_m0, 8'h3C);
        check("m0_rx_pulses", rx_cnt_m0, 1);
        check("m0_tx_ready", tx_ready_m0, 1'b1);
        check("m0_idle_oe", miso_oe_m0, 1'b0);

        // Mode 3: two-byte frame, second TX word captured during first byte
        sclk = 1'b1;
        cycles(8);
        tx_data = 8'h11; tx_valid_m3 = 1'b1;
        cycles(1);
        tx_valid_m3 = 1'b0;
        check("m3_tx_ready_full", tx_ready_m3, 1'b0);
        cs_m3 = 1'b0;
        cycles(8);
        check("m3_busy", busy_m3, 1'b1);
        check("m3_tx_ready_empty", tx_ready_m3, 1'b1);
        check("m3_no_underrun", und_cnt_m3, 0);
        xfer(3, 8'h81, 8, 1'b1, 8'h22, r1);
        xfer(3, 8'h7E, 8, 1'b0, 8'h00, r2);
        cycles(4);
        cs_m3 = 1'b1;
        cycles(8);
        check("m3_ctrl_rx0", r1, 8'h11);
        check("m3_ctrl_rx1", r2, 8'h22);
        check("m3_rx_pulses", rx_cnt_m3, 2);
        check("m3_rx_word0", rx_prev_m3, 8'h81);
        check("m3_rx_word1", rx_last_m3, 8'h7E);
        check("m3_idle_busy", busy_m3, 1'b0);
        sclk = 1'b0;
        cycles(8);

        // Mode 0 with nothing queued: underrun at cs fall, miso stays low
        base_und = und_cnt_m0;
        miso_seen_m0 = 1'b0;
        cs_m0 = 1'b0;
        cycles(8);
        check("ur_underrun_at_cs", und_cnt_m0 - base_und, 1);
        xfer(0, 8'hFF, 8, 1'b0, 8'h00, r1);
        cycles(8);
        cs_m0 = 1'b1;
        cycles(8);
        check("ur_ctrl_rx", r1, 8'h00);
        check("ur_miso_low", miso_seen_m0, 1'b0);
        check("ur_rx_data", rx_data_m0, 8'hFF);

        // Deselect after 5 bits, then a full byte
        base_rx = rx_cnt_m0;
        cs_m0 = 1'b0;
        cycles(8);
        xfer(0, 8'hE7, 5, 1'b0, 8'h00, r1);
        cs_m0 = 1'b1;
        cycles(3);
        check("abort_miso_oe", miso_oe_m0, 1'b0);
        check("abort_busy", busy_m0, 1'b0);
        cycles(8);
        check("abort_no_rx", rx_cnt_m0 - base_rx, 0);
        cs_m0 = 1'b0;
        cycles(8);
        xfer(0, 8'h5A, 8, 1'b0, 8'h00, r1);
        cycles(8);
        cs_m0 = 1'b1;
        cycles(8);
        check("after_abort_rx", rx_data_m0, 8'h5A);
        check("after_abort_pulses", rx_cnt_m0 - base_rx, 1);

        // Reset mid-byte, then a clean frame
        cs_m0 = 1'b0;
        cycles(8);
        xfer(0, 8'h96, 3, 1'b0, 8'h00, r1);
        sclk = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check_reset_m0("midrst");
        cs_m0 = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(8);
        base_rx = rx_cnt_m0;
        cs_m0 = 1'b0;
        cycles(8);
        xfer(0, 8'hC3, 8, 1'b0, 8'h00, r1);
        cycles(8);
        cs_m0 = 1'b1;
        cycles(8);
        check("post_rst_rx", rx_data_m0, 8'hC3);
        check("post_rst_pulses", rx_cnt_m0 - base_rx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
